// File: rtl/hcode_fifo128_rr_arbiter_if.sv
// ap_fifo bundle between NCH source channels and the single host-bound sink.
// The arbiter takes the slave view; the environment (sources and sink) takes master.
interface hcode_fifo128_rr_arbiter_if #(
  parameter int NCH = 4,
  parameter int DW  = 128
);
  logic [NCH*DW-1:0] ch_dout;
  logic [NCH-1:0]    ch_empty_n;
  logic [NCH-1:0]    ch_read;
  logic [DW-1:0]     out_r_din;
  logic              out_r_full;
  logic              out_r_write;

  modport master (
    output ch_dout, ch_empty_n, out_r_full,
    input  ch_read, out_r_din, out_r_write
  );

  modport slave (
    input  ch_dout, ch_empty_n, out_r_full,
    output ch_read, out_r_din, out_r_write
  );
endinterface

// File: rtl/hcode_fifo128_rr_arbiter.sv
// Round-robin merge of NCH ap_fifo sources onto one sink with a zero-latency datapath.
// A grant is released after MAX_BURST beats or IDLE_TIMEOUT consecutive empty cycles.
module hcode_fifo128_rr_arbiter #(
  parameter int NCH          = 4,
  parameter int DW           = 128,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8,
  localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  hcode_fifo128_rr_arbiter_if.slave bus,
  output logic                  grant_valid,
  output logic [CW-1:0]         grant_ch,
  output logic [31:0]           xfer_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   g_q, g_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   pick;
  logic            found;
  logic            rel;
  logic [BW-1:0]   burst_q, burst_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [31:0]     xfer_cnt_q;
  logic            req_g;
  logic            xfer;

  assign req_g = bus.ch_empty_n[g_q];
  assign xfer  = (state_q == GRANT) && req_g && !bus.out_r_full;

  // Strobes are decoded from the registered state so reset kills them immediately.
  always_comb begin
    bus.ch_read = '0;
    if (xfer) bus.ch_read[g_q] = 1'b1;
  end

  assign bus.out_r_write = xfer;
  assign bus.out_r_din   = (state_q == GRANT) ? bus.ch_dout[int'(g_q)*DW +: DW] : '0;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!found && bus.ch_empty_n[(int'(rr_q) + k) % NCH]) begin
        found = 1'b1;
        pick  = CW'((int'(rr_q) + k) % NCH);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          g_d     = pick;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_d = burst_q + 1'b1;
          idle_d  = '0;
          rel     = (burst_q == BW'(MAX_BURST - 1));
        end else if (!req_g) begin
          idle_d  = idle_q + 1'b1;
          rel     = (idle_q == IW'(IDLE_TIMEOUT - 1));
        end else begin
          // sink stall with data pending: hold the grant and the beat count
          idle_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d = IDLE;
      rr_d    = g_q;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      g_q        <= '0;
      rr_q       <= CW'(NCH - 1);
      burst_q    <= '0;
      idle_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      idle_q     <= idle_d;
      xfer_cnt_q <= xfer_cnt_q + {31'd0, xfer};
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_ch    = g_q;
  assign xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_hcode_fifo128_rr_arbiter.sv
// Bench for hcode_fifo128_rr_arbiter: source FIFO models feed a per-channel
// scoreboard, a grant monitor records each grant, and tests compare against the expected grants.
module tb_hcode_fifo128_rr_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 128;
  localparam int CW  = 2;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  hcode_fifo128_rr_arbiter_if #(.NCH(NCH), .DW(DW)) bus_if ();
  logic          grant_valid;
  logic [CW-1:0] grant_ch;
  logic [31:0]   xfer_cnt;

  hcode_fifo128_rr_arbiter #(
    .NCH(NCH), .DW(DW), .MAX_BURST(16), .IDLE_TIMEOUT(8)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus_if),
    .grant_valid(grant_valid), .grant_ch(grant_ch), .xfer_cnt(xfer_cnt)
  );

  typedef struct {int ch; int beats; int cycles; int idle_before;} grant_t;
  typedef struct {int prev; logic [3:0] req; int exp_ch;} arb_vec_t;

  grant_t         grants[$];
  grant_t         cur;
  bit             in_grant;
  int             idle_run;
  logic [DW-1:0]  src  [NCH][$];
  logic [DW-1:0]  expq [NCH][$];
  int             base [NCH];
  logic [NCH-1:0] gap;
  int             checks, failures;
  bit             gv_s;
  int             gch_s;

  function automatic logic [DW-1:0] beat_word(int c, int k);
    return {32'(c), 32'(k), 32'hC0DE0000 | 32'(k), 32'(c * 1000 + k)};
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_w(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic drive_inputs();
    logic [NCH-1:0]    en;
    logic [NCH*DW-1:0] d;
    en = '0;
    d  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (src[c].size() > 0) begin
        en[c]          = ~gap[c];
        d[c*DW +: DW]  = src[c][0];
      end
    end
    bus_if.ch_empty_n = en;
    bus_if.ch_dout    = d;
  endtask

  task automatic load(int c, int n);
    for (int k = 0; k < n; k++) begin
      src[c].push_back(beat_word(c, base[c] + k));
      expq[c].push_back(beat_word(c, base[c] + k));
    end
    base[c] += n;
    drive_inputs();
  endtask

  // One clock: sample at negedge, score any beat, update source models after posedge.
  task automatic cycle();
    logic [NCH-1:0] rd;
    @(negedge ap_clk);
    gv_s  = grant_valid;
    gch_s = int'(grant_ch);
    rd    = bus_if.ch_read;
    if (bus_if.out_r_write) begin
      int c;
      c = -1;
      for (int i = 0; i < NCH; i++) if (rd[i]) c = i;
      chk("read_onehot", $countones(rd), 1);
      chk("read_is_grant", int'(rd), 1 << gch_s);
      if (c >= 0) begin
        if (expq[c].size() > 0) chk_w("sb_data", bus_if.out_r_din, expq[c].pop_front());
        else fail_now("sb_underflow");
      end
    end else if (rd != '0) begin
      chk("read_without_write", int'(rd), 0);
    end
    if (gv_s) begin
      if (!in_grant) begin
        in_grant        = 1'b1;
        cur.ch          = gch_s;
        cur.beats       = 0;
        cur.cycles      = 0;
        cur.idle_before = idle_run;
      end
      cur.cycles++;
      if (bus_if.out_r_write) cur.beats++;
    end else begin
      if (in_grant) begin
        grants.push_back(cur);
        in_grant = 1'b0;
        idle_run = 0;
      end
      idle_run++;
    end
    @(posedge ap_clk);
    #1;
    for (int c = 0; c < NCH; c++)
      if (rd[c] && src[c].size() > 0) void'(src[c].pop_front());
    drive_inputs();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wait_grant(string name, int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      cycle();
      if (gv_s) got = 1'b1;
    end
    if (!got) fail_now(name);
  endtask

  task automatic wait_idle(string name, int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      cycle();
      if (!gv_s) got = 1'b1;
    end
    if (!got) fail_now(name);
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      src[c].delete();
      expq[c].delete();
    end
    gap      = '0;
    grants.delete();
    in_grant = 1'b0;
    idle_run = 0;
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    bus_if.out_r_full = 1'b0;
    clear_model();
    drive_inputs();
    repeat (2) @(posedge ap_clk);
    #3;
    ap_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arb_vec_t vecs[9];
    int       bad;
    int       t2_beats[3];
    checks   = 0;
    failures = 0;
    for (int c = 0; c < NCH; c++) base[c] = 0;
    t2_beats = '{16, 16, 8};
    vecs[0] = '{-1, 4'b1111, 0};
    vecs[1] = '{-1, 4'b0100, 2};
    vecs[2] = '{-1, 4'b1000, 3};
    vecs[3] = '{ 0, 4'b1111, 1};
    vecs[4] = '{ 1, 4'b0001, 0};
    vecs[5] = '{ 2, 4'b0110, 1};
    vecs[6] = '{ 3, 4'b1110, 1};
    vecs[7] = '{ 1, 4'b0010, 1};
    vecs[8] = '{ 2, 4'b1011, 3};

    do_reset();
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_grant_ch", int'(grant_ch), 0);
    chk_w("rst_xfer_cnt", DW'(xfer_cnt), '0);
    chk("rst_ch_read", int'(bus_if.ch_read), 0);
    chk("rst_out_write", int'(bus_if.out_r_write), 0);
    chk_w("rst_out_din", bus_if.out_r_din, '0);

    // arbitration table: establish rr_ptr via a prior grant, then present a request set
    for (int i = 0; i < 9; i++) begin
      do_reset();
      if (vecs[i].prev >= 0) begin
        load(vecs[i].prev, 1);
        wait_grant("arb_prev_grant", 10);
        chk("arb_prev_ch", gch_s, vecs[i].prev);
        wait_idle("arb_prev_release", 30);
      end
      for (int c = 0; c < NCH; c++) if (vecs[i].req[c]) load(c, 1);
      wait_grant("arb_grant", 10);
      chk($sformatf("arb_vec%0d", i), gch_s, vecs[i].exp_ch);
    end

    // T1: reset asserted while beat 5 of a ch0 grant is on the bus
    do_reset();
    load(0, 20);
    load(1, 5);
    wait_grant("t1_grant", 10);
    chk("t1_first_ch", gch_s, 0);
    for (int i = 0; i < 20 && cur.beats < 4; i++) cycle();
    chk("t1_beat5_present", int'(bus_if.out_r_write), 1);
    ap_rst = 1'b1;
    #1;
    chk("t1_rst_ch_read", int'(bus_if.ch_read), 0);
    chk("t1_rst_write", int'(bus_if.out_r_write), 0);
    chk("t1_rst_grant_valid", int'(grant_valid), 0);
    chk_w("t1_rst_xfer_cnt", DW'(xfer_cnt), '0);
    @(negedge ap_clk);
    ap_rst   = 1'b0;
    in_grant = 1'b0;
    grants.delete();
    idle_run = 0;
    wait_grant("t1_regrant", 10);
    chk("t1_ch0_after_reset", gch_s, 0);
    run(40);

    // T2: single source with 40 beats
    do_reset();
    load(2, 40);
    run(80);
    chk("t2_num_grants", grants.size(), 3);
    for (int i = 0; i < grants.size() && i < 3; i++) begin
      chk($sformatf("t2_ch%0d", i), grants[i].ch, 2);
      chk($sformatf("t2_beats%0d", i), grants[i].beats, t2_beats[i]);
      if (i > 0) chk($sformatf("t2_gap%0d", i), grants[i].idle_before, 1);
    end
    if (grants.size() >= 3) chk("t2_timeout_len", grants[2].cycles, 16);
    chk_w("t2_xfer_cnt", DW'(xfer_cnt), DW'(40));
    chk("t2_sb_empty", expq[2].size(), 0);

    // T3: four loaded sources
    do_reset();
    for (int c = 0; c < NCH; c++) load(c, 20);
    run(160);
    chk("t3_num_grants", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++) begin
      chk($sformatf("t3_ch%0d", i), grants[i].ch, i % 4);
      chk($sformatf("t3_beats%0d", i), grants[i].beats, (i < 4) ? 16 : 4);
      if (i > 0) chk($sformatf("t3_gap%0d", i), grants[i].idle_before, 1);
    end
    chk_w("t3_xfer_cnt", DW'(xfer_cnt), DW'(80));

    // T4: 50-cycle sink stall inside a ch1 burst
    do_reset();
    load(1, 30);
    wait_grant("t4_grant", 10);
    for (int i = 0; i < 20 && cur.beats < 5; i++) cycle();
    bus_if.out_r_full = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (!gv_s || bus_if.ch_read != '0 || bus_if.out_r_write) bad++;
    end
    chk("t4_stall_clean", bad, 0);
    chk("t4_beats_held", cur.beats, 5);
    chk("t4_src_untouched", src[1].size(), 25);
    bus_if.out_r_full = 1'b0;
    run(80);
    chk("t4_num_grants", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("t4_burst_total", grants[0].beats, 16);
      chk("t4_burst_cycles", grants[0].cycles, 66);
      chk("t4_second_beats", grants[1].beats, 14);
    end
    chk_w("t4_xfer_cnt", DW'(xfer_cnt), DW'(30));
    chk("t4_sb_empty", expq[1].size(), 0);

    // T5: 7-cycle gap holds the grant, 8-cycle gap releases it
    do_reset();
    load(3, 6);
    wait_grant("t5_grant", 10);
    cycle();
    gap[3] = 1'b1;
    drive_inputs();
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (!gv_s) bad++;
    end
    chk("t5_hold_7", bad, 0);
    gap[3] = 1'b0;
    drive_inputs();
    run(2);
    gap[3] = 1'b1;
    drive_inputs();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (!gv_s) bad++;
    end
    chk("t5_hold_until_8", bad, 0);
    cycle();
    chk("t5_release", int'(gv_s), 0);
    chk("t5_grant_beats", (grants.size() > 0) ? grants[0].beats : -1, 4);
    gap[3] = 1'b0;
    load(0, 1);
    load(1, 1);
    wait_grant("t5_regrant", 10);
    chk("t5_next_ch0", gch_s, 0);
    run(40);

    // T6: transfer counter wrap
    do_reset();
    force dut.xfer_cnt_q = 32'hFFFF_FFFE;
    cycle();
    release dut.xfer_cnt_q;
    chk_w("t6_preload", DW'(xfer_cnt), DW'(32'hFFFF_FFFE));
    load(1, 3);
    run(20);
    chk_w("t6_wrap", DW'(xfer_cnt), DW'(32'h0000_0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
